// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake state, arbiter FSM states and word-address width.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE,
    IGRANT,
    DREAD,
    DWRITE,
    SCFAIL
  } arb_state_t;

  localparam int unsigned WORD_ADDR_W = 30;

endpackage

// File: rtl/llsc_link_reg.sv
// LL/SC link register: remembers the word address of the last LL and compares it against the current data address.
module llsc_link_reg
  import cpu_types_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   set_i,
  input  logic                   clr_i,
  input  logic [WORD_ADDR_W-1:0] set_addr_i,
  input  logic [WORD_ADDR_W-1:0] cmp_addr_i,
  output logic                   hit_o
);

  logic                   valid_q, valid_d;
  logic [WORD_ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (set_i) begin
      valid_d = 1'b1;
      addr_d  = set_addr_i;
    end else if (clr_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign hit_o = valid_q && (addr_q == cmp_addr_i);

endmodule

// File: rtl/memory_arbiter.sv
// Shares the single RAM port between instruction fetch and data access, with LL/SC
// link tracking, an instruction starvation guard and a RAM watchdog.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        datomic,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic        err
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t      state_q, state_d;
  logic [7:0]      to_cnt_q, to_cnt_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            atomic_q, atomic_d;
  logic            err_q, err_d;

  logic grant, timeout, access, done, fail;
  logic d_req, starved, i_done, data_done;
  logic link_hit, link_set, link_clr;

  assign d_req     = dREN | dWEN;
  assign grant     = (state_q == IGRANT) || (state_q == DREAD) || (state_q == DWRITE);
  assign timeout   = (to_cnt_q == 8'(TIMEOUT));
  assign access    = (ramstate == ACCESS);
  assign done      = grant && (access || (ramstate == ERROR) || timeout);
  assign fail      = done && !access;
  assign starved   = iREN && (starve_q == SW'(STARVE_LIMIT));
  assign i_done    = (state_q == IGRANT) && done;
  assign data_done = (((state_q == DREAD) || (state_q == DWRITE)) && done) || (state_q == SCFAIL);

  // Any error completion or SC outcome invalidates the reservation; a plain store only on a hit.
  assign link_set = (state_q == DREAD) && done && !fail && atomic_q;
  assign link_clr = fail || (state_q == SCFAIL) ||
                    ((state_q == DWRITE) && done && (atomic_q || link_hit));

  llsc_link_reg u_link (
    .clk_i      (CLK),
    .rst_i      (RST),
    .set_i      (link_set),
    .clr_i      (link_clr),
    .set_addr_i (daddr[31:2]),
    .cmp_addr_i (daddr[31:2]),
    .hit_o      (link_hit)
  );

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    atomic_d = atomic_q;
    unique case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (d_req && !starved) begin
          atomic_d = datomic;
          if (dWEN) state_d = (datomic && !link_hit) ? SCFAIL : DWRITE;
          else      state_d = DREAD;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      IGRANT, DREAD, DWRITE: begin
        if (done) state_d = IDLE;
        else      to_cnt_d = to_cnt_q + 8'd1;
      end
      SCFAIL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (i_done)
      starve_d = '0;
    else if (data_done)
      starve_d = !iREN ? '0 : (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
    err_d = err_q | fail;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
      starve_q <= '0;
      atomic_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      starve_q <= starve_d;
      atomic_q <= atomic_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    ramREN   = (state_q == IGRANT) || (state_q == DREAD);
    ramWEN   = (state_q == DWRITE);
    ramaddr  = '0;
    ramstore = '0;
    if (state_q == IGRANT)
      ramaddr = iaddr;
    else if ((state_q == DREAD) || (state_q == DWRITE))
      ramaddr = daddr;
    if (state_q == DWRITE)
      ramstore = dstore;

    iload = (i_done && !fail) ? ramload : '0;
    dload = '0;
    if ((state_q == DREAD) && done && !fail)
      dload = ramload;
    else if ((state_q == DWRITE) && done && !fail && atomic_q)
      dload = 32'd1;

    iwait = iREN & !i_done;
    dwait = d_req & !data_done;
  end

  assign err = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter: bench plays CPU and RAM, a transaction-level model predicts every cycle.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned SLIM = 4;
  localparam int unsigned TMO  = 8;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, datomic;
  logic [31:0] iaddr, daddr, dstore, ramload;
  ramstate_t   ramstate;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int unsigned checks = 0;
  int unsigned errors = 0;

  memory_arbiter #(.STARVE_LIMIT(SLIM), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: RAM contents, pending requests, current transaction plan, fairness/link/err state
  logic [31:0] mem [64];
  bit          i_pend, d_pend, busy, ok, done, lv, merr, rst_done;
  int          d_op;   // 0 LW, 1 SW, 2 LL, 3 SC, 4 dREN+dWEN
  int          who;    // 0 none, 1 ifetch, 2 data read, 3 data write, 4 SC refused
  int          cnt, kdone, lat, errat, starve;
  logic [29:0] la;
  logic [31:0] eaddr, exp_il, exp_dl, exp_addr, exp_store;
  logic [1:0]  exp_st;

  task automatic gen_reqs();
    if (!i_pend) begin
      iREN = 1'b0;
      if ($urandom_range(0, 3) != 0) begin
        i_pend = 1;
        iREN   = 1'b1;
        iaddr  = 32'($urandom_range(0, 63)) << 2;
      end
    end
    if (!d_pend) begin
      dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
      if ($urandom_range(0, 3) != 0) begin
        d_pend  = 1;
        d_op    = int'($urandom_range(0, 4));
        daddr   = (($urandom_range(0, 1) != 0) ? 32'h200 : 32'h100) + 32'($urandom_range(0, 1)) * 4;
        dstore  = $urandom;
        dREN    = (d_op == 0 || d_op == 2 || d_op == 4);
        dWEN    = (d_op == 1 || d_op == 3 || d_op == 4);
        datomic = (d_op == 2 || d_op == 3);
      end
    end
  endtask

  task automatic decide();
    who = 0;
    if (d_pend && !(i_pend && starve == SLIM)) begin
      if (d_op == 1 || d_op == 3 || d_op == 4)
        who = (d_op == 3 && !(lv && la == daddr[31:2])) ? 4 : 3;
      else
        who = 2;
    end else if (i_pend) begin
      who = 1;
    end
    if (who != 0) begin
      busy = 1;
      cnt  = 0;
      case ($urandom_range(0, 19))
        0:       lat = 12;
        1:       lat = TMO;
        default: lat = int'($urandom_range(0, 3));
      endcase
      errat = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : 99;
      if (who == 4)                        begin kdone = 0;     ok = 1; end
      else if (errat <= lat)               begin kdone = errat; ok = 0; end
      else if (lat <= TMO)                 begin kdone = lat;   ok = 1; end
      else                                 begin kdone = TMO;   ok = 0; end
    end
  endtask

  initial begin
    foreach (mem[k]) mem[k] = $urandom;
    i_pend = 0; d_pend = 0; busy = 0; lv = 0; merr = 0; starve = 0; rst_done = 0;
    la = '0; who = 0; d_op = 0;

    RST = 1'b1; iREN = 1'b1; iaddr = 32'h40; dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
    daddr = '0; dstore = 32'hFFFF_FFFF; ramstate = ACCESS; ramload = 32'h2402000A;
    #2;
    check("rst_iwait", iwait, 1);
    check("rst_dwait", dwait, 0);
    check("rst_strobe", {ramREN, ramWEN}, 0);
    check("rst_addr", ramaddr, 0);
    check("rst_store", ramstore, 0);
    check("rst_iload", iload, 0);
    check("rst_dload", dload, 0);
    check("rst_err", err, 0);
    iREN = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge CLK);
      gen_reqs();
      if (!busy) begin
        ramstate = FREE;
        ramload  = $urandom;
        #1;
        check("idle_iwait", iwait, i_pend);
        check("idle_dwait", dwait, d_pend);
        check("idle_strobe", {ramREN, ramWEN}, 0);
        check("idle_addr", ramaddr, 0);
        check("idle_loads", {iload, dload}, 0);
        check("err", err, merr);
        decide();
      end else begin
        eaddr = (who == 1) ? iaddr : daddr;
        done  = (cnt == kdone);
        if (who == 4)          ramstate = FREE;
        else if (cnt == errat) ramstate = ERROR;
        else if (cnt == lat)   ramstate = ACCESS;
        else                   ramstate = BUSY;
        ramload = (ramstate == ACCESS) ? mem[eaddr[7:2]] : $urandom;

        exp_il = (done && who == 1 && ok) ? mem[eaddr[7:2]] : 32'h0;
        exp_dl = 32'h0;
        if (done && ok && who == 2)               exp_dl = mem[eaddr[7:2]];
        if (done && ok && who == 3 && d_op == 3)  exp_dl = 32'h1;
        exp_st    = (who == 1 || who == 2) ? 2'b10 : (who == 3) ? 2'b01 : 2'b00;
        exp_addr  = (who == 4) ? 32'h0 : eaddr;
        exp_store = (who == 3) ? dstore : 32'h0;
        #1;
        check("iwait", iwait, i_pend && !(done && who == 1));
        check("dwait", dwait, d_pend && !(done && who >= 2));
        check("iload", iload, exp_il);
        check("dload", dload, exp_dl);
        check("strobe", {ramREN, ramWEN}, exp_st);
        check("ramaddr", ramaddr, exp_addr);
        check("ramstore", ramstore, exp_store);
        check("err", err, merr);

        if (!rst_done && cyc > 150 && who == 3 && !done) begin
          #1 RST = 1'b1;
          #1;
          check("rst_mid_strobe", {ramREN, ramWEN}, 0);
          check("rst_mid_addr", ramaddr, 0);
          check("rst_mid_dwait", dwait, 1);
          check("rst_mid_err", err, 0);
          @(posedge CLK);
          #1 RST = 1'b0;
          busy = 0; starve = 0; lv = 0; merr = 0; rst_done = 1;
        end else if (done) begin
          if (!ok) begin merr = 1; lv = 0; end
          if (who == 1) begin
            starve = 0;
            i_pend = 0;
          end else begin
            starve = !i_pend ? 0 : (starve < SLIM) ? starve + 1 : starve;
            if (ok && who == 2 && d_op == 2) begin lv = 1; la = daddr[31:2]; end
            if (ok && who == 3) mem[eaddr[7:2]] = dstore;
            if (who == 3 && (d_op == 3 || (lv && la == daddr[31:2]))) lv = 0;
            if (who == 4) lv = 0;
            d_pend = 0;
          end
          busy = 0;
        end else begin
          cnt++;
        end
      end
    end

    check("rst_inject", rst_done, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
